// File: rtl/cim_pkg.sv
// Shared types and defaults for the ping-pong CIM unit controller.
package cim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LOADED,
    SWAP
  } cim_state_t;

  localparam int DEF_ROWS   = 64;
  localparam int DEF_ROW_W  = 2304;
  localparam int DEF_PSUM_W = 1152;

  // Next core in rotation, wrapping from n-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cim_psum_pipe.sv
// Carries {cim_en, active core index} CORE_LAT cycles to pick the matching core PSUM.
// Define PSUM_OUT_REG_EN to add one registered output stage (latency CORE_LAT+1).
module cim_psum_pipe
  import cim_pkg::*;
#(
  parameter int N_CORE   = 2,
  parameter int PSUM_W   = DEF_PSUM_W,
  parameter int CORE_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cim_en,
  input  logic [$clog2(N_CORE)-1:0]    core_idx,
  input  logic [N_CORE*PSUM_W-1:0]     core_psum,
  output logic [PSUM_W-1:0]            psum_out,
  output logic                         psum_valid
);

  localparam int IDX_W = $clog2(N_CORE);

  logic             vld_p [CORE_LAT];
  logic [IDX_W-1:0] idx_p [CORE_LAT];
  logic             tail_vld;
  logic [PSUM_W-1:0] tail_psum;

  // Stage p0..p(CORE_LAT-1): issue tag tracks the core's own compute latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CORE_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= cim_en;
      for (int i = 1; i < CORE_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    idx_p[0] <= core_idx;
    for (int i = 1; i < CORE_LAT; i++) idx_p[i] <= idx_p[i-1];
  end

  assign tail_vld  = vld_p[CORE_LAT-1];
  assign tail_psum = core_psum[idx_p[CORE_LAT-1]*PSUM_W +: PSUM_W];

`ifdef PSUM_OUT_REG_EN
  // Output stage: registered copy of the selected PSUM
  always_ff @(posedge clk) begin
    if (rst) begin
      psum_valid <= 1'b0;
      psum_out   <= '0;
    end else begin
      psum_valid <= tail_vld;
      if (tail_vld) psum_out <= tail_psum;
    end
  end
`else
  logic [PSUM_W-1:0] psum_hold;

  // Output stage: pass-through on valid, last result held otherwise
  always_ff @(posedge clk) begin
    if (rst)           psum_hold <= '0;
    else if (tail_vld) psum_hold <= tail_psum;
  end

  assign psum_valid = tail_vld;
  assign psum_out   = tail_vld ? tail_psum : psum_hold;
`endif

endmodule

// File: rtl/cim_unit_pp.sv
// N-core CIM unit controller: active core computes while the shadow core is reloaded.
// Optional macro PSUM_OUT_REG_EN adds one registered stage on psum_out/psum_valid.
module cim_unit_pp
  import cim_pkg::*;
#(
  parameter int N_CORE   = 2,
  parameter int ROWS     = DEF_ROWS,
  parameter int ROW_W    = DEF_ROW_W,
  parameter int PSUM_W   = DEF_PSUM_W,
  parameter int CORE_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ROW_W-1:0]            wr_data,
  input  logic                        rd_req,
  input  logic [$clog2(ROWS)-1:0]     rd_row,
  output logic                        rd_ready,
  output logic                        rd_valid,
  output logic [ROW_W-1:0]            rd_data,
  input  logic                        swap_req,
  input  logic                        cim_en,
  output logic [N_CORE-1:0]           core_stdw,
  output logic [N_CORE-1:0]           core_stdr,
  output logic [$clog2(ROWS)-1:0]     core_std_a,
  output logic [ROW_W-1:0]            core_weight_in,
  output logic [N_CORE-1:0]           core_cim_en,
  input  logic [N_CORE*ROW_W-1:0]     core_weight_out,
  input  logic [N_CORE*PSUM_W-1:0]    core_psum,
  output logic [PSUM_W-1:0]           psum_out,
  output logic                        psum_valid,
  output logic [$clog2(N_CORE)-1:0]   active_core,
  output logic                        shadow_loaded
);

  localparam int IDX_W = $clog2(N_CORE);
  localparam int A_W   = $clog2(ROWS);

  cim_state_t       state;
  logic [A_W-1:0]   cnt;
  logic [IDX_W-1:0] shadow;
  logic             wr_acc;
  logic             rd_acc;
  logic             rd_vld_p1;
  logic [IDX_W-1:0] rd_core_p1;

  assign shadow        = IDX_W'(wrap_inc(32'(active_core), 32'(N_CORE)));
  assign wr_ready      = (state == IDLE) || (state == LOAD);
  assign wr_acc        = wr_valid && wr_ready;
  assign rd_ready      = ((state == IDLE) || (state == LOADED)) && !wr_acc;
  assign rd_acc        = rd_req && rd_ready;
  assign shadow_loaded = (state == LOADED);
  assign core_weight_in = wr_data;

  // Writes win the shared address bus; only the shadow core is ever strobed
  always_comb begin
    core_stdw   = '0;
    core_stdr   = '0;
    core_std_a  = cnt;
    core_cim_en = '0;
    if (wr_acc) begin
      core_stdw[shadow] = 1'b1;
    end else if (rd_acc) begin
      core_stdr[shadow] = 1'b1;
      core_std_a        = rd_row;
    end
    if (cim_en) core_cim_en[active_core] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      active_core <= '0;
    end else begin
      unique case (state)
        IDLE, LOAD: begin
          if (wr_acc) begin
            cnt   <= cnt + A_W'(1);
            state <= (cnt == A_W'(ROWS - 1)) ? LOADED : LOAD;
          end
        end
        LOADED: begin
          // Hold off while a CIM op issues so its tag carries the old core
          if (swap_req && !cim_en) begin
            state       <= SWAP;
            active_core <= shadow;
            cnt         <= '0;
          end
        end
        SWAP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: core readback appears one cycle after STDR
  always_ff @(posedge clk) begin
    if (rst) rd_vld_p1 <= 1'b0;
    else     rd_vld_p1 <= rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rd_acc) rd_core_p1 <= shadow;
  end

  assign rd_valid = rd_vld_p1;
  assign rd_data  = rd_vld_p1 ? core_weight_out[rd_core_p1*ROW_W +: ROW_W] : '0;

  cim_psum_pipe #(
    .N_CORE   (N_CORE),
    .PSUM_W   (PSUM_W),
    .CORE_LAT (CORE_LAT)
  ) u_psum_pipe (
    .clk        (clk),
    .rst        (rst),
    .cim_en     (cim_en),
    .core_idx   (active_core),
    .core_psum  (core_psum),
    .psum_out   (psum_out),
    .psum_valid (psum_valid)
  );

endmodule

// File: doc/cim_unit_pp.md
Name: cim_unit_pp

Overview:
Parametrised N-core CIM unit controller with ping-pong weight update. One core is "active" and serves CIM operations. The next core in rotation is the "shadow" core; it is streamed new weight rows through a valid/ready port and can be read back. On a swap request the shadow core becomes active, with no stall of in-flight PSUMs. The block sits between the layer controller and the CIM core array, and drives each core's standard-write (STDW), standard-read (STDR) and address pins.

Parameters:
N_CORE, 2, number of cores in rotation (>=2)
ROWS, 64, weight rows per core
ROW_W, 2304, bits per weight row
PSUM_W, 1152, PSUM bits per core
CORE_LAT, 2, cycles from cim_en to core PSUM valid (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wr_valid  in  1  weight row beat valid
wr_ready  out  1  weight row beat accepted when both high
wr_data  in  ROW_W  weight row
rd_req  in  1  readback request for shadow core
rd_row  in  $clog2(ROWS)  readback row address
rd_ready  out  1  rd_req accepted when both high
rd_valid  out  1  readback data valid
rd_data  out  ROW_W  readback row
swap_req  in  1  request to make loaded shadow core active
cim_en  in  1  CIM operation on active core this cycle
core_stdw  out  N_CORE  one-hot per-core write strobe
core_stdr  out  N_CORE  one-hot per-core read strobe
core_std_a  out  $clog2(ROWS)  row address to all cores
core_weight_in  out  ROW_W  write data to all cores
core_cim_en  out  N_CORE  one-hot CIM enable (active core)
core_weight_out  in  N_CORE*ROW_W  per-core readback, valid 1 cycle after STDR
core_psum  in  N_CORE*PSUM_W  per-core PSUM
psum_out  out  PSUM_W  selected PSUM
psum_valid  out  1  psum_out valid
active_core  out  $clog2(N_CORE)  index of active core
shadow_loaded  out  1  shadow core holds a full new weight set

Behaviour:
- Reset values: active_core=0, state IDLE, row counter 0. All strobes, rd_valid, psum_valid and shadow_loaded are 0. rd_data=0, psum_out=0.
- shadow index = (active_core+1) mod N_CORE, with wrap-around at N_CORE-1.
- FSM states:
  - IDLE: wr_ready=1. An accepted beat writes row 0 and moves to LOAD.
  - LOAD: wr_ready=1. Each accepted beat writes row cnt. Acceptance of row ROWS-1 moves to LOADED.
  - LOADED: wr_ready=0, shadow_loaded=1.
  - SWAP: one cycle. active_core advances, row counter clears, then IDLE.
- Write beat handling: in the accept cycle, core_stdw[shadow]=1, core_std_a=cnt and core_weight_in=wr_data, all combinational.
- Swap: taken in LOADED when swap_req=1 and cim_en=0. swap_req while cim_en=1 is held off until cim_en=0; the requester keeps it asserted. swap_req in IDLE or LOAD is ignored.
- Readback:
  - rd_ready=1 in IDLE/LOADED when no write beat is accepted that cycle. A write beat always takes priority over a read.
  - An accepted read drives core_stdr[shadow]=1 and core_std_a=rd_row.
  - Next cycle: rd_valid=1 and rd_data=core_weight_out slice of the core sampled at request.
  - Reads in LOAD or SWAP are not accepted.
- CIM path:
  - core_cim_en = cim_en one-hot on active_core.
  - A CORE_LAT-deep shift register carries {cim_en, active_core index}.
  - psum_valid = tail valid. psum_out = core_psum slice of the carried index. A swap therefore never re-routes in-flight results.
  - psum_out holds its last value when psum_valid=0.
- Never more than one bit set in core_stdw|core_stdr. The active core never receives STDW/STDR.
- rst mid-load discards partial rows: state IDLE, counter 0. Pipeline valids clear the same cycle.

Optional Feature:
PSUM_OUT_REG_EN: when defined, psum_out/psum_valid get one extra output register stage (latency CORE_LAT+1, reset 0). When undefined, latency is CORE_LAT.

Decomposition:
- Package cim_pkg: FSM state enum (IDLE, LOAD, LOADED, SWAP) and default constants for ROWS, ROW_W, PSUM_W.
- One sub-module, cim_psum_pipe: the CORE_LAT valid/index shift register plus output mux.

Test Plan:
- N_CORE=2, ROWS=4: stream 4 beats (0xA..0xD) with wr_valid held high -> core_stdw=2'b10 at addresses 0..3 on consecutive cycles; shadow_loaded=1 on the cycle after beat 3; wr_ready=0 afterwards.
- Loaded, swap_req=1 while cim_en=1 for 3 cycles -> no swap; active_core becomes 1 one cycle after cim_en drops; shadow_loaded=0.
- cim_en pulse at active_core=0, swap at next cycle, CORE_LAT=2 -> psum_valid 2 cycles after pulse, psum_out = core0 PSUM slice.
- rd_req with rd_row=2 in LOADED -> core_stdr[1]=1, core_std_a=2; next cycle rd_valid=1, rd_data = core1 row-2 value.
- N_CORE=3: three load/swap cycles -> active_core 0->1->2->0, with shadow wrapping to 0.
- rst asserted after 2 of 4 beats -> IDLE, counter 0; the next beat writes row 0.
